snes_ctrl_responder: RTL

- Synthesizable controller-side end of the SNES serial pad protocol; the console drives latch and clock, and this block answers on the data line.
- A host (TAS replay logic) pushes one DATA_W-bit frame per console poll into a 2-entry buffer.
- On each latch the head frame is parallel-loaded, then shifted out MSB first on successive console clock rising edges.
- Replaces the discrete shift register on the controller port.

---
 rtl/snes_ctrl_responder.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/snes_ctrl_responder.sv
// ---------------------------------------------------------------------------
// snes_ctrl_responder
//
// Controller-side end of the SNES serial pad protocol. The console drives
// snes_lat and snes_clk; this block answers on d0. A host pushes one frame
// per console poll into a 2-entry FIFO. Each accepted latch parallel-loads
// the head frame (or IDLE_WORD when the FIFO is empty), then every
// synchronized snes_clk rising edge shifts the frame out MSB first.
//
// Ports:
//   sys_clk        in   system clock (48 MHz nominal)
//   rst            in   synchronous, active-high reset
//   snes_lat       in   console latch, asynchronous to sys_clk
//   snes_clk       in   console data clock, asynchronous, idles high
//   d0             out  serial data to console
//   frame_data     in   host frame, DATA_W bits
//   frame_valid    in   host offers frame_data
//   frame_ready    out  FIFO has space; push when valid && ready
//   frame_consumed out  one-cycle pulse when a buffered frame is retired
//   underrun       out  one-cycle pulse when a latch finds the FIFO empty
//   latch_count    out  accepted latches, wraps at 16'hFFFF
//   buf_level      out  frames buffered, 0..2
//
// Build option:
//   LATCH_FILTER_EN  when defined, a latch is accepted only after the
//                    synchronized latch has been high for MIN_LATCH_CYCLES
//                    consecutive cycles; shorter pulses are ignored.
//
// States:
//   state       | meaning
//   ST_IDLE     | no frame in flight, d0 = FILL_BIT
//   ST_LATCHED  | frame loaded, latch still high, clock edges ignored
//   ST_SHIFTING | latch low, each clock rise shifts one bit out
// ---------------------------------------------------------------------------
module snes_ctrl_responder #(
    parameter int unsigned DATA_W           = 32,
    parameter logic [31:0] IDLE_WORD        = 32'hFFFF_FFFF,
    parameter logic        FILL_BIT         = 1'b1,
    parameter int unsigned MIN_LATCH_CYCLES = 96
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              snes_lat,
    input  logic              snes_clk,
    output logic              d0,
    input  logic [DATA_W-1:0] frame_data,
    input  logic              frame_valid,
    output logic              frame_ready,
    output logic              frame_consumed,
    output logic              underrun,
    output logic [15:0]       latch_count,
    output logic [1:0]        buf_level
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    if (DATA_W < 8 || DATA_W > 32 || MIN_LATCH_CYCLES < 2) begin : g_bad_param
        $error("snes_ctrl_responder: DATA_W must be 8..32 and MIN_LATCH_CYCLES >= 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LATCHED,
        ST_SHIFTING
    } state_t;

    state_t            state;
    logic              lat_s1, lat_s2, lat_d;
    logic              clk_s1, clk_s2, clk_d;
    logic              lat_rise, lat_fall, clk_rise;
    logic              lat_accept;
    logic [DATA_W-1:0] buf_mem [2];
    logic              rd_ptr, wr_ptr;
    logic              buf_empty;
    logic              push, pop;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic              idle_load;

    // Two-flop synchronizers plus one delay flop for edge detection.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            lat_s1 <= 1'b0;
            lat_s2 <= 1'b0;
            lat_d  <= 1'b0;
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_d  <= 1'b1;
        end else begin
            lat_s1 <= snes_lat;
            lat_s2 <= lat_s1;
            lat_d  <= lat_s2;
            clk_s1 <= snes_clk;
            clk_s2 <= clk_s1;
            clk_d  <= clk_s2;
        end
    end

    assign lat_rise = lat_s2 & ~lat_d;
    assign lat_fall = ~lat_s2 & lat_d;
    assign clk_rise = clk_s2 & ~clk_d;

`ifdef LATCH_FILTER_EN
    localparam int FILT_W = $clog2(MIN_LATCH_CYCLES + 1);

    logic              armed;
    logic [FILT_W-1:0] filt_cnt;

    // filt_cnt holds how many more high cycles are needed after the current
    // one; the rise cycle itself counts as the first high cycle.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            armed    <= 1'b0;
            filt_cnt <= '0;
        end else if (lat_rise && state != ST_LATCHED) begin
            armed    <= 1'b1;
            filt_cnt <= FILT_W'(MIN_LATCH_CYCLES - 1);
        end else if (armed) begin
            if (!lat_s2 || filt_cnt <= FILT_W'(1)) begin
                armed <= 1'b0;
            end else begin
                filt_cnt <= filt_cnt - FILT_W'(1);
            end
        end
    end

    assign lat_accept = armed && lat_s2 && (filt_cnt <= FILT_W'(1));
`else
    assign lat_accept = lat_rise && (state != ST_LATCHED);
`endif

    assign buf_empty   = (buf_level == 2'd0);
    assign frame_ready = (buf_level != 2'd2);
    assign push        = frame_valid && frame_ready;
    // The head is retired only when the latch window closes, so an abort by a
    // later latch never pops a second time.
    assign pop         = (state == ST_LATCHED) && lat_fall && !idle_load;
    assign d0          = shreg[DATA_W-1];

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            buf_level  <= 2'd0;
        end else begin
            if (push) begin
                buf_mem[wr_ptr] <= frame_data;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   buf_level <= buf_level + 2'd1;
                2'b01:   buf_level <= buf_level - 2'd1;
                default: buf_level <= buf_level;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            shreg          <= {DATA_W{FILL_BIT}};
            bit_cnt        <= '0;
            idle_load      <= 1'b0;
            underrun       <= 1'b0;
            frame_consumed <= 1'b0;
            latch_count    <= 16'd0;
        end else begin
            underrun       <= 1'b0;
            frame_consumed <= pop;
            if (lat_accept) begin
                // The FIFO level seen here is pre-push, so a frame pushed in
                // this same cycle waits for the next latch.
                state       <= ST_LATCHED;
                idle_load   <= buf_empty;
                underrun    <= buf_empty;
                latch_count <= latch_count + 16'd1;
                shreg       <= buf_empty ? IDLE_WORD[DATA_W-1:0] : buf_mem[rd_ptr];
                bit_cnt     <= '0;
            end else begin
                case (state)
                    ST_LATCHED: begin
                        if (lat_fall) begin
                            state   <= ST_SHIFTING;
                            bit_cnt <= '0;
                        end
                    end
                    ST_SHIFTING: begin
                        if (clk_rise) begin
                            shreg   <= {shreg[DATA_W-2:0], FILL_BIT};
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
